if_pc_stage: RTL and testbench
==============================

Name: if_pc_stage

Overview:
- Instruction-fetch stage of the pipelined ARMv8 core.
- Holds the 64-bit program counter and computes the sequential PC (PC+4).
- Selects the next PC from the sequential value or a taken-branch target; the target is produced by the downstream branch-target adder and resolved in EX/MEM.
- Registers the fetched instruction and its PC into the IF/ID pipeline register, with stall and flush control from the hazard/branch logic.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- branch_taken  input  1  EX/MEM: redirect fetch to branch_target.
- branch_target  input  64  branch-target adder result.
- instr_in  input  32  instruction memory read data for the address on pc_out (combinational read).
- pc_out  output  64  current PC, drives instruction memory address.
- pc_plus4  output  64  combinational pc_out + PC_STEP.
- ifid_pc  output  64  PC of the instruction held in IF/ID.
- ifid_pc_plus4  output  64  PC+4 of the instruction held in IF/ID.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- misalign_err  output  1  sticky flag: a taken branch target had bits [1:0] != 0.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: sampled only on a rising clk edge.
  - Reset dominates every other input.
- Reset values (the clock edge with reset=1):
  - pc_out = RESET_PC.
  - ifid_pc = 0, ifid_pc_plus4 = 0.
  - ifid_instr = 32'hD503201F (NOP).
  - ifid_valid = 0, misalign_err = 0.
- pc_plus4: combinational pc_out + PC_STEP, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.
- PC register update, priority order on each rising edge:
  1. reset: load RESET_PC.
  2. branch_taken=1: load {branch_target[63:2], 2'b00}. This applies even if stall=1, because the branch overrides the stall.
  3. stall=1: hold.
  4. otherwise: load pc_plus4.
- IF/ID register update, same priority:
  1. reset: reset values above.
  2. branch_taken=1 (flush): ifid_valid = 0, ifid_instr = NOP, ifid_pc and ifid_pc_plus4 = 0. This holds regardless of stall.
  3. stall=1: hold all IF/ID fields.
  4. otherwise: ifid_pc = pc_out, ifid_pc_plus4 = pc_plus4, ifid_instr = instr_in, ifid_valid = 1.
- misalign_err:
  - Set on any edge where branch_taken=1 and branch_target[1:0] != 0.
  - Stays set until reset; never cleared otherwise.
  - The PC still loads the aligned target.
- Latency:
  - A redirect asserted in cycle N makes pc_out equal the target in cycle N+1.
  - The instruction at the target appears in IF/ID in cycle N+2.
  - Exactly one bubble enters IF/ID: the flush at edge N.
- Consecutive branches: each taken edge independently redirects and flushes; the last one wins.
- Stall released: the next edge resumes normal sequencing from the held PC. No instruction is lost or duplicated.
- Reset asserted mid-stream: on that edge all state goes to reset values regardless of stall or branch_taken. The first fetch after deassertion is at RESET_PC.
- No internal state other than the PC, the IF/ID fields, and misalign_err.

Test Plan:
- Reset then free-run (stall=0, branch_taken=0, instr_in = PC[31:0]), RESET_PC=0:
  - After reset, pc_out = 0, 4, 8, 12 on successive cycles.
  - ifid_pc lags pc_out by one cycle, with ifid_instr = 0, 4, 8 and ifid_valid = 1 from the second cycle.
- Stall for 3 cycles at pc_out=0x10:
  - pc_out stays 0x10 and IF/ID stays {pc 0xC, valid 1} for 3 edges.
  - After release, pc_out = 0x14 and then 0x18, with no duplicate 0xC and no skipped 0x10 in IF/ID.
- Branch at pc_out=0x20 with branch_target=0x100:
  - Next cycle: pc_out = 0x100, ifid_valid = 0, ifid_instr = 0xD503201F.
  - Following cycle: ifid_pc = 0x100, ifid_valid = 1.
- branch_taken=1 and stall=1 together, target 0x200:
  - pc_out = 0x200 and IF/ID is flushed (valid 0); the branch beats the stall.
- Misaligned target 0x403 on a taken branch:
  - pc_out = 0x400 and misalign_err = 1, which stays 1 through 10 further cycles.
  - The next reset clears it to 0.
- Wrap and mid-stream reset:
  - Force pc_out = 0xFFFF_FFFF_FFFF_FFFC via a branch: the next pc_out is 0 and pc_plus4 reads 0 at that PC.
  - Then assert reset together with branch_taken=1: pc_out = RESET_PC, ifid_valid = 0, misalign_err = 0.

Source files
------------

// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: program counter, sequential PC generation, branch
// redirect and the IF/ID pipeline register with stall/flush control.
module if_pc_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [63:0] pc_out,
    output logic [63:0] pc_plus4,
    output logic [63:0] ifid_pc,
    output logic [63:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        misalign_err
);

    localparam logic [31:0] NopInstr = 32'hD503201F;

    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [63:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;

    logic [63:0] seq_pc;
    logic [63:0] aligned_target;

    // Sequential PC wraps modulo 2^64; target low bits are forced to word alignment.
    always_comb begin
        seq_pc         = pc_q + 64'(PC_STEP);
        aligned_target = {branch_target[63:2], 2'b00};
    end

    // Next-state: a taken branch overrides a stall and flushes IF/ID to a bubble.
    always_comb begin
        pc_d            = pc_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        misalign_d      = misalign_q;
        if (branch_taken) begin
            pc_d            = aligned_target;
            ifid_pc_d       = 64'h0;
            ifid_pc_plus4_d = 64'h0;
            ifid_instr_d    = NopInstr;
            ifid_valid_d    = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d            = seq_pc;
            ifid_pc_d       = pc_q;
            ifid_pc_plus4_d = seq_pc;
            ifid_instr_d    = instr_in;
            ifid_valid_d    = 1'b1;
        end
    end

    // State registers with synchronous reset dominating all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            ifid_pc_q       <= 64'h0;
            ifid_pc_plus4_q <= 64'h0;
            ifid_instr_q    <= NopInstr;
            ifid_valid_q    <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
            misalign_q      <= misalign_d;
        end
    end

    // Output assignments.
    always_comb begin
        pc_out        = pc_q;
        pc_plus4      = seq_pc;
        ifid_pc       = ifid_pc_q;
        ifid_pc_plus4 = ifid_pc_plus4_q;
        ifid_instr    = ifid_instr_q;
        ifid_valid    = ifid_valid_q;
        misalign_err  = misalign_q;
    end

endmodule

// File: tb/tb_if_pc_stage.sv
// Self-checking bench for if_pc_stage: a reference model pushes expected
// post-edge state to a scoreboard queue, popped and compared after each edge.
module tb_if_pc_stage;

    localparam logic [63:0] NOP = 64'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] instr_in;
    logic [63:0] pc_out, pc_plus4, ifid_pc, ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        ifid_valid, misalign_err;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [63:0] ipc4;
        logic [31:0] instr;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [63:0] m_pc, m_ipc, m_ipc4;
    logic [31:0] m_instr;
    logic        m_valid, m_err;
    bit          m_init = 0;

    int n_total = 0;
    int n_bad   = 0;

    if_pc_stage #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    // Instruction memory: word returned is the low half of its address.
    assign instr_in = pc_out[31:0];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [63:0] tgt);
        exp_t e;
        @(negedge clk);
        reset = rst;
        stall = stl;
        branch_taken = br;
        branch_target = tgt;
        #1;
        if (m_init) check_eq("pc_plus4", pc_plus4, m_pc + 64'd4);
        if (rst) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_ipc4 = 64'h0;
            m_instr = NOP[31:0]; m_valid = 1'b0; m_err = 1'b0;
            m_init = 1;
        end else if (br) begin
            m_pc = {tgt[63:2], 2'b00};
            m_ipc = 64'h0; m_ipc4 = 64'h0; m_instr = NOP[31:0]; m_valid = 1'b0;
            if (tgt[1:0] != 2'b00) m_err = 1'b1;
        end else if (!stl) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 64'd4; m_instr = m_pc[31:0]; m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
        end
        e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4;
        e.instr = m_instr; e.valid = m_valid; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("pc_out", pc_out, e.pc);
        check_eq("ifid_pc", ifid_pc, e.ipc);
        check_eq("ifid_pc_plus4", ifid_pc_plus4, e.ipc4);
        check_eq("ifid_instr", 64'(ifid_instr), 64'(e.instr));
        check_eq("ifid_valid", 64'(ifid_valid), 64'(e.valid));
        check_eq("misalign_err", 64'(misalign_err), 64'(e.err));
    endtask

    initial begin
        // Reset, then free-run
        step(1, 0, 0, 0);
        step(1, 1, 1, 64'h40);
        check_eq("rst_pc", pc_out, 64'h0);
        check_eq("rst_instr", 64'(ifid_instr), NOP);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check_eq("run_pc", pc_out, 64'h10);
        check_eq("run_ifid_pc", ifid_pc, 64'hC);
        check_eq("run_instr", 64'(ifid_instr), 64'hC);

        // Stall three edges at 0x10
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check_eq("stall_pc", pc_out, 64'h10);
        check_eq("stall_ifid_pc", ifid_pc, 64'hC);
        step(0, 0, 0, 0);
        check_eq("release_pc", pc_out, 64'h14);
        check_eq("release_ifid_pc", ifid_pc, 64'h10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check_eq("pre_branch_pc", pc_out, 64'h20);

        // Branch to 0x100
        step(0, 0, 1, 64'h100);
        check_eq("br_pc", pc_out, 64'h100);
        check_eq("br_valid", 64'(ifid_valid), 64'h0);
        check_eq("br_instr", 64'(ifid_instr), NOP);
        step(0, 0, 0, 0);
        check_eq("br_ifid_pc", ifid_pc, 64'h100);
        check_eq("br_ifid_valid", 64'(ifid_valid), 64'h1);

        // Branch beats stall
        step(0, 0, 0, 0);
        step(0, 1, 1, 64'h200);
        check_eq("brstall_pc", pc_out, 64'h200);
        check_eq("brstall_valid", 64'(ifid_valid), 64'h0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Back-to-back branches, last wins
        step(0, 0, 1, 64'h300);
        step(0, 0, 1, 64'h500);
        check_eq("b2b_pc", pc_out, 64'h500);
        step(0, 0, 0, 0);

        // Misaligned target: aligned load, sticky flag
        step(0, 0, 1, 64'h403);
        check_eq("mis_pc", pc_out, 64'h400);
        check_eq("mis_err", 64'(misalign_err), 64'h1);
        for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)), 0, 0);
        check_eq("mis_sticky", 64'(misalign_err), 64'h1);
        step(1, 0, 0, 0);
        check_eq("mis_clear", 64'(misalign_err), 64'h0);

        // Wrap at top of address space (misaligned to set the flag again)
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("wrap_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("wrap_plus4", pc_plus4, 64'h0);
        step(0, 0, 0, 0);
        check_eq("wrap_next", pc_out, 64'h0);
        check_eq("wrap_ifid_pc4", ifid_pc_plus4, 64'h0);
        step(0, 0, 0, 0);

        // Reset with branch asserted
        step(1, 0, 1, 64'h700);
        check_eq("rstbr_pc", pc_out, 64'h0);
        check_eq("rstbr_valid", 64'(ifid_valid), 64'h0);
        check_eq("rstbr_err", 64'(misalign_err), 64'h0);

        // Random mix against the model
        for (int i = 0; i < 200; i++) begin
            logic [63:0] t;
            t = {$urandom(), $urandom()};
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), t);
        end

        if (sb.size() != 0) check_eq("sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
